// File: rtl/ddr_rx_demux_p.sv
// DDR receiver deframer: aligns a word stream on rx_sync and packs FRAME beats
// into one wide output word, with a frame-rate clock and lock/misalignment status.
module ddr_rx_demux_p #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 4,
    parameter int NUM_CH = 1
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [DATA_W-1:0]               DDR_rx,
    input  logic                            rx_valid,
    input  logic                            rx_sync,
    input  logic                            err_clr,
    output logic [NUM_CH*WORDS*DATA_W-1:0]  dout,
    output logic                            dout_valid,
    output logic                            RxClkDiv,
    output logic                            locked,
    output logic                            sync_err
);

    localparam int FRAME = NUM_CH * WORDS;
    localparam int OUT_W = FRAME * DATA_W;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] SLOT_HALF = CNT_W'(FRAME / 2);
    localparam logic [CNT_W-1:0] SLOT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_sync_q,  rx_sync_d;

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  slot_q,       slot_d;
    logic              frame_done_q, frame_done_d;
    logic [OUT_W-1:0]  frame_buf_q,  frame_buf_d;
    logic [OUT_W-1:0]  dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              rxclkdiv_q,   rxclkdiv_d;
    logic              sync_err_q,   sync_err_d;

    logic              wr_en;
    logic [CNT_W-1:0]  wr_slot;
    logic              err_set;

    always_comb begin
        rx_data_d  = DDR_rx;
        rx_valid_d = rx_valid;
        rx_sync_d  = rx_sync;
    end

    // Slot sequencing and alignment decisions, all made on the registered beat.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_slot      = slot_q;
        err_set      = 1'b0;

        if (rx_valid_q) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (rx_sync_q) begin
                        state_d = ST_LOCKED;
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOT_ONE;
                    end
                end
                ST_LOCKED: begin
                    wr_en = 1'b1;
                    if (rx_sync_q && (slot_q != '0)) begin
                        // Misaligned sync: restart the frame here, dropping the partial one.
                        err_set = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOT_ONE;
                    end else if (slot_q == SLOT_LAST) begin
                        slot_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_ONE;
                    end
                end
            endcase
        end
    end

    // Slot k lands in channel k % NUM_CH, word k / NUM_CH; first word is least significant.
    always_comb begin
        frame_buf_d = frame_buf_q;
        if (wr_en) begin
            for (int k = 0; k < FRAME; k++) begin
                if (wr_slot == CNT_W'(k)) begin
                    frame_buf_d[(k % NUM_CH) * WORDS * DATA_W + (k / NUM_CH) * DATA_W +: DATA_W] = rx_data_q;
                end
            end
        end
    end

    always_comb begin
        dout_d       = frame_done_q ? frame_buf_q : dout_q;
        dout_valid_d = frame_done_q;
        rxclkdiv_d   = (state_d == ST_LOCKED) && (slot_d < SLOT_HALF);
        sync_err_d   = err_set | (sync_err_q & ~err_clr);
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sync_q    <= 1'b0;
            state_q      <= ST_UNLOCKED;
            slot_q       <= '0;
            frame_done_q <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rxclkdiv_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_sync_q    <= rx_sync_d;
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rxclkdiv_q   <= rxclkdiv_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // NOTE: the assembly buffer has no reset; a frame is only published after every
    // slot has been rewritten since the last sync, so stale contents never reach dout.
    always_ff @(posedge Clk) begin
        frame_buf_q <= frame_buf_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign RxClkDiv   = rxclkdiv_q;
    assign locked     = (state_q == ST_LOCKED);
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_ddr_rx_demux_p.sv
// Directed bench for ddr_rx_demux_p: default-geometry vector table plus hand
// sequences for mid-frame reset and a two-channel, two-word instance.
module tb_ddr_rx_demux_p;

    logic Clk = 1'b0;
    logic Reset;
    always #4 Clk = ~Clk;

    // Default instance: DATA_W=16, WORDS=4, NUM_CH=1.
    logic [15:0] rx0_data;
    logic        rx0_valid, rx0_sync, clr0;
    logic [63:0] dout0;
    logic        dv0, ck0, lk0, err0;

    // Two-channel instance: DATA_W=16, WORDS=2, NUM_CH=2.
    logic [15:0] rx1_data;
    logic        rx1_valid, rx1_sync, clr1;
    logic [63:0] dout1;
    logic        dv1, ck1, lk1, err1;

    ddr_rx_demux_p dut0 (
        .Clk(Clk), .Reset(Reset), .DDR_rx(rx0_data), .rx_valid(rx0_valid),
        .rx_sync(rx0_sync), .err_clr(clr0), .dout(dout0), .dout_valid(dv0),
        .RxClkDiv(ck0), .locked(lk0), .sync_err(err0)
    );

    ddr_rx_demux_p #(.DATA_W(16), .WORDS(2), .NUM_CH(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .DDR_rx(rx1_data), .rx_valid(rx1_valid),
        .rx_sync(rx1_sync), .err_clr(clr1), .dout(dout1), .dout_valid(dv1),
        .RxClkDiv(ck1), .locked(lk1), .sync_err(err1)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        clr;
        logic        dv;
        logic        lk;
        logic        err;
        logic        ck;
        logic [63:0] dout;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] F1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] F2 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] F3 = 64'h0104_0103_0102_0101;
    localparam logic [63:0] F4 = 64'h0304_0303_0302_0301;
    localparam logic [63:0] G1 = 64'h00B1_00B0_00A1_00A0;

    function automatic vec_t vec(input logic v, input logic s, input logic [15:0] d,
                                 input logic clr, input logic dv, input logic lk,
                                 input logic err, input logic ck, input logic [63:0] dout);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.clr = clr;
        r.dv = dv; r.lk = lk; r.err = err; r.ck = ck; r.dout = dout;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step0(input logic v, input logic s, input logic [15:0] d, input logic clr);
        rx0_valid = v; rx0_sync = s; rx0_data = d; clr0 = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic s, input logic [15:0] d);
        rx1_valid = v; rx1_sync = s; rx1_data = d; clr1 = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic expect0(input string tag, input logic dv, input logic lk,
                           input logic err, input logic ck, input logic [63:0] dout);
        check({tag, " dout_valid"}, {63'd0, dv0},  {63'd0, dv});
        check({tag, " locked"},     {63'd0, lk0},  {63'd0, lk});
        check({tag, " sync_err"},   {63'd0, err0}, {63'd0, err});
        check({tag, " RxClkDiv"},   {63'd0, ck0},  {63'd0, ck});
        check({tag, " dout"},       dout0,         dout);
    endtask

    task automatic expect1(input string tag, input logic dv, input logic lk,
                           input logic ck, input logic [63:0] dout);
        check({tag, " dout_valid"}, {63'd0, dv1}, {63'd0, dv});
        check({tag, " locked"},     {63'd0, lk1}, {63'd0, lk});
        check({tag, " RxClkDiv"},   {63'd0, ck1}, {63'd0, ck});
        check({tag, " dout"},       dout1,        dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin
        //            v  s  data      clr  dv lk er ck dout
        // Beats before the first sync are dropped, then lock on 0x0001.
        tbl.push_back(vec(1, 0, 16'h0011, 0,  0, 0, 0, 0, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0012, 0,  0, 0, 0, 0, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0013, 0,  0, 0, 0, 0, 64'd0));
        tbl.push_back(vec(1, 1, 16'h0001, 0,  0, 0, 0, 0, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0002, 0,  0, 1, 0, 1, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0003, 0,  0, 1, 0, 0, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0004, 0,  0, 1, 0, 0, 64'd0));
        // Sync on slot 0 while locked is silent; frame 1 strobes two edges after 0x0004.
        tbl.push_back(vec(1, 1, 16'h0005, 0,  0, 1, 0, 1, 64'd0));
        tbl.push_back(vec(1, 0, 16'h0006, 0,  1, 1, 0, 1, F1));
        tbl.push_back(vec(1, 0, 16'h0007, 0,  0, 1, 0, 0, F1));
        tbl.push_back(vec(1, 0, 16'h0008, 0,  0, 1, 0, 0, F1));
        tbl.push_back(vec(0, 0, 16'hdead, 0,  0, 1, 0, 1, F1));
        tbl.push_back(vec(0, 0, 16'hdead, 0,  1, 1, 0, 1, F2));
        // Gapped frame: valid low three cycles between beats 1 and 2.
        tbl.push_back(vec(1, 1, 16'h0101, 0,  0, 1, 0, 1, F2));
        tbl.push_back(vec(1, 0, 16'h0102, 0,  0, 1, 0, 1, F2));
        tbl.push_back(vec(0, 0, 16'hbeef, 0,  0, 1, 0, 0, F2));
        tbl.push_back(vec(0, 0, 16'hbeef, 0,  0, 1, 0, 0, F2));
        tbl.push_back(vec(0, 0, 16'hbeef, 0,  0, 1, 0, 0, F2));
        tbl.push_back(vec(1, 0, 16'h0103, 0,  0, 1, 0, 0, F2));
        tbl.push_back(vec(1, 0, 16'h0104, 0,  0, 1, 0, 0, F2));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  0, 1, 0, 1, F2));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  1, 1, 0, 1, F3));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  0, 1, 0, 1, F3));
        // Resync at slot 2: partial frame dropped, error raised, next frame good.
        tbl.push_back(vec(1, 1, 16'h0201, 0,  0, 1, 0, 1, F3));
        tbl.push_back(vec(1, 0, 16'h0202, 0,  0, 1, 0, 1, F3));
        tbl.push_back(vec(1, 1, 16'h0301, 0,  0, 1, 0, 0, F3));
        tbl.push_back(vec(1, 0, 16'h0302, 0,  0, 1, 1, 1, F3));
        tbl.push_back(vec(1, 0, 16'h0303, 0,  0, 1, 1, 0, F3));
        tbl.push_back(vec(1, 0, 16'h0304, 0,  0, 1, 1, 0, F3));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  0, 1, 1, 1, F3));
        tbl.push_back(vec(0, 0, 16'h0000, 1,  1, 1, 0, 1, F4));
        // Second resync with err_clr on the same edge the error sets: stays set.
        tbl.push_back(vec(1, 1, 16'h0401, 0,  0, 1, 0, 1, F4));
        tbl.push_back(vec(1, 0, 16'h0402, 0,  0, 1, 0, 1, F4));
        tbl.push_back(vec(1, 1, 16'h0501, 0,  0, 1, 0, 0, F4));
        tbl.push_back(vec(0, 0, 16'h0000, 1,  0, 1, 1, 1, F4));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  0, 1, 1, 1, F4));
        tbl.push_back(vec(0, 0, 16'h0000, 0,  0, 1, 1, 1, F4));

        Reset = 1'b1;
        rx0_valid = 1'b0; rx0_sync = 1'b0; rx0_data = '0; clr0 = 1'b0;
        rx1_valid = 1'b0; rx1_sync = 1'b0; rx1_data = '0; clr1 = 1'b0;
        step0(0, 0, 16'h0000, 0);
        step0(0, 0, 16'h0000, 0);
        expect0("reset", 0, 0, 0, 0, 64'd0);
        expect1("reset1", 0, 0, 0, 64'd0);
        Reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step0(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].clr);
            expect0($sformatf("row%0d", i), tbl[i].dv, tbl[i].lk, tbl[i].err, tbl[i].ck, tbl[i].dout);
        end

        // Reset asserted with the counter at slot 2; sync_err is still set beforehand.
        step0(1, 1, 16'h0A01, 0);
        step0(1, 0, 16'h0A02, 0);
        step0(1, 0, 16'h0A03, 0);
        expect0("pre_reset", 0, 1, 1, 0, F4);
        Reset = 1'b1;
        step0(1, 1, 16'h0A04, 0);
        expect0("mid_reset", 0, 0, 0, 0, 64'd0);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step0(1, 0, 16'h0B00 + 16'(i), 0);
            expect0($sformatf("post_reset%0d", i), 0, 0, 0, 0, 64'd0);
        end
        step0(0, 0, 16'h0000, 0);

        // Two channels, two words: slots alternate ch0/ch1.
        step1(1, 1, 16'h00A0);
        expect1("ch2_a0", 0, 0, 0, 64'd0);
        step1(1, 0, 16'h00B0);
        expect1("ch2_b0", 0, 1, 1, 64'd0);
        step1(1, 0, 16'h00A1);
        expect1("ch2_a1", 0, 1, 0, 64'd0);
        step1(1, 0, 16'h00B1);
        expect1("ch2_b1", 0, 1, 0, 64'd0);
        step1(0, 0, 16'h0000);
        expect1("ch2_lat1", 0, 1, 1, 64'd0);
        step1(0, 0, 16'h0000);
        expect1("ch2_strobe", 1, 1, 1, G1);
        check("ch2_ch0_bits", {32'd0, dout1[31:0]},  64'h0000_0000_00A1_00A0);
        check("ch2_ch1_bits", {32'd0, dout1[63:32]}, 64'h0000_0000_00B1_00B0);
        step1(0, 0, 16'h0000);
        expect1("ch2_hold", 0, 1, 1, G1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
